// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half/word load-store alignment onto a word-addressed registered-read memory
//
// Purpose: accepts one byte-addressed access at a time and turns it into one or
// two word-addressed memory cycles. Stores get lane-shifted data and byte
// enables. Loads get the addressed bytes extracted and sign/zero extended.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   req, we, addr, size, uns,  request; sampled only while idle
//   wdata
//   busy, done, err, rdata     status, completion pulse, reject flag, load result
//   mem_addr, mem_be, mem_we,  word-addressed memory port, 1-cycle read latency
//   mem_wdata, mem_rdata
//
// Build option: LSU_MISALIGNED_EN accepts any byte offset and splits accesses
// that cross a word boundary. Without it, misaligned halves/words are rejected.

module lsu_align #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic                     we,
  input  logic [31:0]              addr,
  input  logic [1:0]               size,
  input  logic                     uns,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [3:0]               mem_be,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_ACC1, S_ACC2, S_CAP, S_DONE} state_t;
  state_t state;

  // Decode of the incoming request, used only on the accepting cycle.
  logic [1:0]               req_k;
  logic [ADDRESS_WIDTH-1:0] req_w0;
  logic [3:0]               req_mask;
  logic [2:0]               req_bytes;
  logic                     req_span;
  logic                     req_illegal;
  logic                     unused_addr;

  assign req_k       = addr[1:0];
  assign req_w0      = addr[ADDRESS_WIDTH+1:2];
  assign unused_addr = ^addr[31:ADDRESS_WIDTH+2];

  always_comb begin
    req_mask  = 4'hF;
    req_bytes = 3'd4;
    case (size)
      2'b00:   begin req_mask = 4'h1; req_bytes = 3'd1; end
      2'b01:   begin req_mask = 4'h3; req_bytes = 3'd2; end
      default: ;
    endcase
  end

  assign req_span = ({1'b0, req_k} + req_bytes) > 3'd4;

  always_comb begin
    req_illegal = (size == 2'b11);
`ifdef LSU_MISALIGNED_EN
    // every offset is accepted; crossing accesses are split through ACC2
`else
    if ((size == 2'b01 && req_k[0]) || (size == 2'b10 && req_k != 2'd0))
      req_illegal = 1'b1;
`endif
  end

  // Latched request.
  logic                     we_r;
  logic                     uns_r;
  logic                     span_r;
  logic [1:0]               k_r;
  logic [1:0]               size_r;
  logic [3:0]               mask_r;
  logic [ADDRESS_WIDTH-1:0] w0_r;
  logic [DATA_WIDTH-1:0]    wdata_r;
  logic [DATA_WIDTH-1:0]    word0_r;

  // Second-cycle shifts; only meaningful when k_r != 0 (spanning).
  logic [2:0] sh_be2;
  logic [5:0] sh_wd2;
  assign sh_be2 = 3'd4 - {1'b0, k_r};
  assign sh_wd2 = 6'd32 - {1'b0, k_r, 3'b000};

  // Load extraction from the final memory word (plus word0 when spanning).
  logic [2*DATA_WIDTH-1:0] load_pair;
  logic [DATA_WIDTH-1:0]   load_shifted;
  logic [DATA_WIDTH-1:0]   load_result;

  always_comb begin
    load_pair    = span_r ? {mem_rdata, word0_r} : {{DATA_WIDTH{1'b0}}, mem_rdata};
    load_shifted = DATA_WIDTH'(load_pair >> {k_r, 3'b000});
    case (size_r)
      2'b00:   load_result = uns_r ? {{(DATA_WIDTH-8){1'b0}}, load_shifted[7:0]}
                                   : {{(DATA_WIDTH-8){load_shifted[7]}}, load_shifted[7:0]};
      2'b01:   load_result = uns_r ? {{(DATA_WIDTH-16){1'b0}}, load_shifted[15:0]}
                                   : {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
      default: load_result = load_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_be    <= 4'h0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      we_r      <= 1'b0;
      uns_r     <= 1'b0;
      span_r    <= 1'b0;
      k_r       <= 2'd0;
      size_r    <= 2'd0;
      mask_r    <= 4'h0;
      w0_r      <= '0;
      wdata_r   <= '0;
      word0_r   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          mem_be <= 4'h0;
          mem_we <= 1'b0;
          if (req) begin
            we_r    <= we;
            uns_r   <= uns;
            span_r  <= req_span;
            k_r     <= req_k;
            size_r  <= size;
            mask_r  <= req_mask;
            w0_r    <= req_w0;
            wdata_r <= wdata;
            busy    <= 1'b1;
            if (req_illegal) begin
              // Rejected: no memory cycle, straight to the completion pulse.
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state     <= S_ACC1;
              mem_addr  <= req_w0;
              mem_be    <= req_mask << req_k;
              mem_we    <= we;
              mem_wdata <= wdata << {req_k, 3'b000};
            end
          end
        end
        S_ACC1: begin
          if (span_r) begin
            // Upper part of the access goes to the next word, wrapping at the top.
            state     <= S_ACC2;
            mem_addr  <= w0_r + ADDRESS_WIDTH'(1);
            mem_be    <= mask_r >> sh_be2;
            mem_we    <= we_r;
            mem_wdata <= wdata_r >> sh_wd2;
          end else begin
            mem_be <= 4'h0;
            mem_we <= 1'b0;
            if (we_r) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_CAP;
            end
          end
        end
        S_ACC2: begin
          mem_be <= 4'h0;
          mem_we <= 1'b0;
          if (we_r) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            // Read data for w0 arrives now; w1's arrives during CAP.
            word0_r <= mem_rdata;
            state   <= S_CAP;
          end
        end
        S_CAP: begin
          rdata <= load_result;
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - self-checking bench for lsu_align
module tb_lsu_align;
  localparam int AW = 9;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = 4 << AW;

  logic          clk = 1'b0;
  logic          reset, req, we, uns;
  logic          busy, done, err, mem_we;
  logic [31:0]   addr, wdata, rdata, mem_wdata, mem_rdata;
  logic [1:0]    size;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_align #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .size(size),
    .uns(uns), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Word memory with registered read, driven by the DUT.
  logic [31:0] ram [0:NWORDS-1];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= ram[mem_addr];
  end

  // Reference: flat byte memory.
  logic [7:0] refm [0:NBYTES-1];

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [1:0]  s;
    logic        u;
    logic [31:0] d;
    int          lat;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  logic [AW-1:0] c1_addr, c2_addr;
  logic [3:0]    c1_be, c2_be, end_be;
  logic          c1_we, saw_we, end_we, end_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_access(input logic w, input logic [31:0] a, input logic [1:0] s,
                                     input logic u, input logic [31:0] d,
                                     output int lat, output logic e, output logic [31:0] rd);
    int k, n, base;
    logic [31:0] v;
    k = int'(a[1:0]);
    base = int'(a[AW+1:0]);
    e = (s == 2'b11);
`ifndef LSU_MISALIGNED_EN
    if (s == 2'b01 && (k % 2) != 0) e = 1'b1;
    if (s == 2'b10 && k != 0) e = 1'b1;
`endif
    rd = 32'h0;
    if (e) begin
      lat = 1;
      return;
    end
    n = 1 << s;
    if (w) begin
      for (int i = 0; i < n; i++) refm[(base + i) % NBYTES] = d[8*i +: 8];
      lat = (k + n > 4) ? 3 : 2;
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | ({24'h0, refm[(base + i) % NBYTES]} << (8 * i));
      if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
      rd = v;
      lat = (k + n > 4) ? 4 : 3;
    end
  endfunction

  task automatic access(input logic w, input logic [31:0] a, input logic [1:0] s,
                        input logic u, input logic [31:0] d,
                        output int lat, output logic e, output logic [31:0] rd);
    @(negedge clk);
    chk("done_is_single_pulse", {31'h0, done}, 32'h0);
    req = 1'b1; we = w; addr = a; size = s; uns = u; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    lat = -1; e = 1'b0; rd = 32'h0; saw_we = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) begin c1_addr = mem_addr; c1_be = mem_be; c1_we = mem_we; end
      if (n == 2) begin c2_addr = mem_addr; c2_be = mem_be; end
      if (mem_we) saw_we = 1'b1;
      if (done) begin
        lat = n; e = err; rd = rdata;
        end_be = mem_be; end_we = mem_we; end_busy = busy;
        break;
      end
    end
  endtask

  task automatic check_common(input string tag, input logic w, input int lat, input int elat,
                              input logic e, input logic ee, input logic [31:0] rd,
                              input logic [31:0] erd);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_err"}, {31'h0, e}, {31'h0, ee});
    if (!w || ee) chk({tag, "_rdata"}, rd, erd);
    chk({tag, "_mem_we_seen"}, {31'h0, saw_we}, {31'h0, w & ~ee});
    chk({tag, "_done_be_we_busy"}, {28'h0, end_be, end_we, end_busy}, 32'h1);
  endtask

  initial begin
    vec_t tbl [12];
    int lat, elat;
    logic e, ee;
    logic [31:0] rd, erd, a;
    logic w, u;
    logic [1:0] s;

    //          w     addr           size   uns   wdata          lat err   rdata
    tbl[0]  = '{1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEADBEEF, 2, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,        3, 1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'h12345680, 2, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,        3, 1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0,        3, 1'b0, 32'h00000080};
    tbl[5]  = '{1'b0, 32'h0000_0012, 2'b01, 1'b0, 32'h0,        3, 1'b0, 32'hFFFF80AD};
    tbl[6]  = '{1'b0, 32'h0000_0011, 2'b00, 1'b1, 32'h0,        3, 1'b0, 32'h000000BE};
    tbl[7]  = '{1'b1, 32'h0000_0040, 2'b11, 1'b0, 32'h55555555, 1, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h1111CAFE, 2, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h0000_0022, 2'b01, 1'b1, 32'h0,        3, 1'b0, 32'h0000CAFE};
    tbl[10] = '{1'b0, 32'h8000_0010, 2'b10, 1'b0, 32'h0,        3, 1'b0, 32'h80ADBEEF};
    tbl[11] = '{1'b0, 32'h0000_0020, 2'b10, 1'b1, 32'h0,        3, 1'b0, 32'hCAFE0000};

    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; size = 2'b00; uns = 1'b0; wdata = 32'h0;
    for (int i = 0; i < NBYTES; i++) refm[i] = 8'h0;
    for (int i = 0; i < NWORDS; i++) ram[i] <= 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_status", {29'h0, busy, done, err}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_ctl", {23'h0, mem_addr} | {27'h0, mem_be, mem_we}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);

    for (int i = 0; i < 12; i++) begin
      access(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].d, lat, e, rd);
      ref_access(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].u, tbl[i].d, elat, ee, erd);
      check_common($sformatf("tbl%0d", i), tbl[i].w, lat, tbl[i].lat, e, tbl[i].e, rd, tbl[i].rd);
      if (i == 0) begin
        chk("tbl0_mem_addr", 32'(c1_addr), 32'h4);
        chk("tbl0_mem_be_we", {27'h0, c1_be, c1_we}, 32'h1F);
      end
    end

    // A request held through DONE must be ignored.
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h50; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("req_in_done_ignored", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("req_in_done_still_idle", {31'h0, busy}, 32'h0);

`ifdef LSU_MISALIGNED_EN
    access(1'b1, 32'h0F, 2'b01, 1'b0, 32'h0000A55A, lat, e, rd);
    ref_access(1'b1, 32'h0F, 2'b01, 1'b0, 32'h0000A55A, elat, ee, erd);
    check_common("span_store", 1'b1, lat, 3, e, 1'b0, rd, 32'h0);
    chk("span_store_first", {19'h0, 4'(c1_addr), c1_be, 5'h0}, {19'h0, 4'h3, 4'h8, 5'h0});
    chk("span_store_second", {19'h0, 4'(c2_addr), c2_be, 5'h0}, {19'h0, 4'h4, 4'h1, 5'h0});
    access(1'b0, 32'h0F, 2'b01, 1'b0, 32'h0, lat, e, rd);
    ref_access(1'b0, 32'h0F, 2'b01, 1'b0, 32'h0, elat, ee, erd);
    check_common("span_load", 1'b0, lat, 4, e, 1'b0, rd, 32'hFFFFA55A);
    access(1'b0, 32'(NBYTES - 2), 2'b10, 1'b1, 32'h0, lat, e, rd);
    ref_access(1'b0, 32'(NBYTES - 2), 2'b10, 1'b1, 32'h0, elat, ee, erd);
    check_common("wrap_load", 1'b0, lat, 4, e, 1'b0, rd, erd);
    chk("wrap_second_addr", 32'(c2_addr), 32'h0);
    a = 32'h0F; s = 2'b01; wdata = 32'h1357;
`else
    access(1'b1, 32'h21, 2'b10, 1'b0, 32'hCAFEF00D, lat, e, rd);
    ref_access(1'b1, 32'h21, 2'b10, 1'b0, 32'hCAFEF00D, elat, ee, erd);
    check_common("misaligned_word", 1'b1, lat, 1, e, 1'b1, rd, 32'h0);
    access(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, lat, e, rd);
    ref_access(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, elat, ee, erd);
    check_common("misaligned_half", 1'b0, lat, 1, e, 1'b1, rd, 32'h0);
    a = 32'h30; s = 2'b10; wdata = 32'h11223344;
`endif

    // Reset during ACC1 of a store: only the first write may land.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; size = s; uns = 1'b0;
    @(posedge clk);
    #1 req = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_acc1_we", {31'h0, mem_we}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_acc1_status", {29'h0, busy, done, err}, 32'h0);
    chk("rst_acc1_mem", {23'h0, mem_addr} | {27'h0, mem_be, mem_we} | mem_wdata | rdata, 32'h0);
`ifdef LSU_MISALIGNED_EN
    refm[32'h0F] = 8'h57;
`else
    for (int i = 0; i < 4; i++) refm[32'h30 + i] = wdata[8*i +: 8];
`endif
    access(1'b0, a, s, 1'b0, 32'h0, lat, e, rd);
    ref_access(1'b0, a, s, 1'b0, 32'h0, elat, ee, erd);
    check_common("after_rst_load", 1'b0, lat, elat, e, 1'b0, rd, erd);

    // Randomized accesses against the byte-level model.
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0, 1: a[AW+1:0] = (AW+2)'($urandom_range(0, 63));
        2:    a[AW+1:0] = (AW+2)'($urandom_range(NBYTES - 8, NBYTES - 1));
        default: ;
      endcase
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      wdata = $urandom;
      access(w, a, s, u, wdata, lat, e, rd);
      ref_access(w, a, s, u, wdata, elat, ee, erd);
      check_common($sformatf("rnd%0d", i), w, lat, elat, e, ee, rd, erd);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < NWORDS; i++)
      chk($sformatf("ram_word_%0d", i), ram[i],
          {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
